// File: rtl/debug_exception_sequencer_if.sv
// Signal bundle between the write-stage debug detector / exception unit and the #DB sequencer.
// master drives the detector inputs and the ack; slave is the sequencer.
interface debug_exception_sequencer_if;
    logic        wr_debug_prepare;
    logic [3:0]  wr_debug_code_reg;
    logic [3:0]  wr_debug_write_reg;
    logic [3:0]  wr_debug_read_reg;
    logic        wr_debug_step_reg;
    logic        wr_debug_task_reg;
    logic        gd_fault;
    logic [31:0] dr6;
    logic        exc_ack;
    logic [31:0] dr6_to_reg;
    logic        dr6_write;
    logic        exc_req;
    logic [7:0]  exc_vector;
    logic        exc_is_fault;
    logic        busy;
    logic [7:0]  dropped_cnt;

    modport master (
        output wr_debug_prepare, wr_debug_code_reg, wr_debug_write_reg, wr_debug_read_reg,
               wr_debug_step_reg, wr_debug_task_reg, gd_fault, dr6, exc_ack,
        input  dr6_to_reg, dr6_write, exc_req, exc_vector, exc_is_fault, busy, dropped_cnt
    );

    modport slave (
        input  wr_debug_prepare, wr_debug_code_reg, wr_debug_write_reg, wr_debug_read_reg,
               wr_debug_step_reg, wr_debug_task_reg, gd_fault, dr6, exc_ack,
        output dr6_to_reg, dr6_write, exc_req, exc_vector, exc_is_fault, busy, dropped_cnt
    );
endinterface

// File: rtl/debug_exception_sequencer.sv
// Debug exception sequencer: latches breakpoint hits, writes the new DR6 for one cycle,
// then holds a #DB request until the exception unit acknowledges it.
module debug_exception_sequencer #(
    parameter logic [7:0]  DB_VECTOR      = 8'd1,
    parameter logic [31:0] DR6_FIXED_ONES = 32'hFFFF0FF0
) (
    input  logic                         clk,
    input  logic                         rst,
    debug_exception_sequencer_if.slave   dbg
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_REQ     = 2'd3;

    // BT/BS/BD are sticky in DR6; bit 12 is reserved-zero.
    localparam logic [31:0] DR6_STICKY_MASK = 32'h0000E000;
    localparam logic [31:0] DR6_ZERO_MASK   = 32'h00001000;

    logic [1:0]  state;
    logic [3:0]  hits;
    logic        bs;
    logic        bt;
    logic        bd;
    logic        kind_fault;
    logic [7:0]  dropped;
    logic        drop_event;
    logic [31:0] dr6_new;

    // In IDLE a simultaneous prepare loses to GD; while busy any pulse is lost.
    always_comb begin
        drop_event = 1'b0;
        if (state != ST_IDLE)
            drop_event = dbg.wr_debug_prepare | dbg.gd_fault;
        else
            drop_event = dbg.wr_debug_prepare & dbg.gd_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hits       <= '0;
            bs         <= 1'b0;
            bt         <= 1'b0;
            bd         <= 1'b0;
            kind_fault <= 1'b0;
            dropped    <= '0;
        end else begin
            if (drop_event && dropped != 8'hFF)
                dropped <= dropped + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (dbg.gd_fault) begin
                        state      <= ST_WRITE;
                        kind_fault <= 1'b1;
                        hits       <= '0;
                        bs         <= 1'b0;
                        bt         <= 1'b0;
                        bd         <= 1'b1;
                    end else if (dbg.wr_debug_prepare) begin
                        state      <= ST_CAPTURE;
                        kind_fault <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    hits  <= dbg.wr_debug_code_reg | dbg.wr_debug_write_reg | dbg.wr_debug_read_reg;
                    bs    <= dbg.wr_debug_step_reg;
                    bt    <= dbg.wr_debug_task_reg;
                    bd    <= 1'b0;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (dbg.exc_ack)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dr6_new = (DR6_FIXED_ONES
                   | {16'b0, bt, bs, bd, 1'b0, 8'b0, hits}
                   | (dbg.dr6 & DR6_STICKY_MASK))
                  & ~DR6_ZERO_MASK;
    end

    assign dbg.dr6_write    = (state == ST_WRITE);
    assign dbg.dr6_to_reg   = (state == ST_WRITE) ? dr6_new : '0;
    assign dbg.exc_req      = (state == ST_REQ);
    assign dbg.exc_vector   = (state == ST_REQ) ? DB_VECTOR : '0;
    assign dbg.exc_is_fault = (state == ST_REQ) & kind_fault;
    assign dbg.busy         = (state != ST_IDLE);
    assign dbg.dropped_cnt  = dropped;

endmodule
